// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures high/low phase of each period, checks against expected lengths, tracks lock.
// Outputs are registered on the edge that samples the triggering condition; there is no backpressure.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             div_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [GW-1:0]    good_q, good_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             rise;

  assign rise = div_in & ~div_q;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    good_d     = good_q;
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    pv_d       = 1'b0;
    err_d      = 1'b0;
    locked_d   = locked_q;

    if (!enable) begin
      state_d  = ST_IDLE;
      hcnt_d   = '0;
      lcnt_d   = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (rise) begin
            state_d = ST_HIGH;
            hcnt_d  = CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (div_in) begin
            if (hcnt_q == CNT_MAX) begin
              err_d    = 1'b1;
              good_d   = '0;
              locked_d = 1'b0;
              state_d  = ST_SYNC;
              hcnt_d   = '0;
              lcnt_d   = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end else begin
            state_d = ST_LOW;
            lcnt_d  = CNT_W'(1);
          end
        end
        default: begin
          if (!div_in) begin
            if (lcnt_q == CNT_MAX) begin
              err_d    = 1'b1;
              good_d   = '0;
              locked_d = 1'b0;
              state_d  = ST_SYNC;
              hcnt_d   = '0;
              lcnt_d   = '0;
            end else begin
              lcnt_d = lcnt_q + 1'b1;
            end
          end else begin
            // Rising edge closes the period and opens the next high phase.
            high_len_d = hcnt_q;
            low_len_d  = lcnt_q;
            pv_d       = 1'b1;
            state_d    = ST_HIGH;
            hcnt_d     = CNT_W'(1);
            lcnt_d     = '0;
            if (hcnt_q == exp_high && lcnt_q == exp_low) begin
              good_d   = (good_q == GOOD_MAX) ? GOOD_MAX : good_q + 1'b1;
              locked_d = (good_d == GOOD_MAX);
            end else begin
              err_d    = 1'b1;
              good_d   = '0;
              locked_d = 1'b0;
            end
          end
        end
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= 1'b0;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      good_q     <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      pv_q       <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_in;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      good_q     <= good_d;
      high_len_q <= high_len_d;
      low_len_q  <= low_len_d;
      pv_q       <= pv_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign high_len     = high_len_q;
  assign low_len      = low_len_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor against a sample-queue reference model.
module tb_clk_div_monitor;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int MAXC     = (1 << CNT_W) - 1;
  localparam int MAXE     = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             div_in;
  logic [CNT_W-1:0] exp_high;
  logic [CNT_W-1:0] exp_low;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div_in(div_in),
    .exp_high(exp_high), .exp_low(exp_low),
    .high_len(high_len), .low_len(low_len),
    .period_valid(period_valid), .locked(locked),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: samples since the last accepted rise are kept in a queue,
  // and a period is read off the queue as (count of ones, count of zeros).
  int m_q[$];
  bit m_prev, m_armed, m_hunt, m_pv, m_err;
  int m_streak, m_errs, m_hl, m_ll;

  function automatic void model_reset();
    m_q.delete();
    m_prev = 0; m_armed = 0; m_hunt = 1; m_pv = 0; m_err = 0;
    m_streak = 0; m_errs = 0; m_hl = 0; m_ll = 0;
  endfunction

  function automatic void model_step(bit en, bit d, int eh, int el);
    int ones, zeros;
    m_pv = 0; m_err = 0;
    if (!en) begin
      m_armed = 0; m_q.delete(); m_streak = 0;
    end else if (!m_armed) begin
      m_armed = 1; m_hunt = 1; m_q.delete();
    end else if (m_hunt) begin
      if (d && !m_prev) begin m_hunt = 0; m_q.delete(); m_q.push_back(1); end
    end else begin
      ones = 0; zeros = 0;
      foreach (m_q[i]) if (m_q[i] == 1) ones++; else zeros++;
      if (d && zeros > 0) begin
        m_hl = ones; m_ll = zeros; m_pv = 1;
        if (ones == eh && zeros == el) m_streak++;
        else begin m_err = 1; m_streak = 0; end
        m_q.delete(); m_q.push_back(1);
      end else if ((d ? ones : zeros) + 1 > MAXC) begin
        m_err = 1; m_streak = 0; m_hunt = 1; m_q.delete();
      end else begin
        m_q.push_back(d ? 1 : 0);
      end
    end
    if (m_err && m_errs < MAXE) m_errs++;
    m_prev = d;
  endfunction

  task automatic check_outputs();
    check_eq("period_valid", period_valid, m_pv);
    check_eq("err", err, m_err);
    check_eq("locked", locked, (m_streak >= LOCK_CNT));
    check_eq("err_cnt", err_cnt, m_errs);
    check_eq("high_len", high_len, m_hl);
    check_eq("low_len", low_len, m_ll);
  endtask

  task automatic step(input bit en, input bit d);
    @(negedge clk);
    enable = en;
    div_in = d;
    @(posedge clk);
    #1;
    model_step(en, d, int'(exp_high), int'(exp_low));
    check_outputs();
  endtask

  task automatic drive_period(input int h, input int l);
    for (int i = 0; i < h; i++) step(1, 1);
    for (int i = 0; i < l; i++) step(1, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_high_len"}, high_len, 0);
    check_eq({tag, "_low_len"}, low_len, 0);
    check_eq({tag, "_pv"}, period_valid, 0);
    check_eq({tag, "_locked"}, locked, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    int h, l, eh, el;
    rst = 1'b1; enable = 1'b0; div_in = 1'b0; exp_high = 8'd1; exp_low = 8'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Divide-by-2 against 1/1: lock on the fourth period.
    step(1, 0);
    for (int i = 0; i < 8; i++) drive_period(1, 1);
    check_eq("lock_div2", locked, 1);

    // Divide-by-3 as 2/1.
    exp_high = 8'd2; exp_low = 8'd1;
    for (int i = 0; i < 8; i++) drive_period(2, 1);
    check_eq("lock_div3", locked, 1);
    check_eq("len_div3_h", high_len, 2);

    // Locked at 1/1, then a 2/2 stream mismatches each period.
    exp_high = 8'd1; exp_low = 8'd1;
    for (int i = 0; i < 8; i++) drive_period(1, 1);
    for (int i = 0; i < 4; i++) drive_period(2, 2);

    // Stall high beyond the counter range.
    for (int i = 0; i < 8; i++) drive_period(1, 1);
    for (int i = 0; i < 300; i++) step(1, 1);
    check_eq("stall_locked", locked, 0);
    for (int i = 0; i < 8; i++) drive_period(1, 1);

    // Enable drop mid-period, then resume and relock.
    exp_high = 8'd3; exp_low = 8'd2;
    for (int i = 0; i < 6; i++) drive_period(3, 2);
    step(1, 1); step(1, 1);
    for (int i = 0; i < 3; i++) step(0, 1);
    check_eq("drop_len_hold", high_len, 3);
    step(1, 0);
    for (int i = 0; i < 8; i++) drive_period(3, 2);
    check_eq("relock", locked, 1);

    // Random periods, expected lengths and occasional enable drops.
    for (int s = 0; s < 60; s++) begin
      eh = $urandom_range(1, 6); el = $urandom_range(1, 6);
      exp_high = CNT_W'(eh); exp_low = CNT_W'(el);
      for (int p = 0; p < int'($urandom_range(2, 8)); p++) begin
        h = ($urandom_range(0, 9) < 7) ? eh : $urandom_range(1, 7);
        l = ($urandom_range(0, 9) < 7) ? el : $urandom_range(1, 7);
        drive_period(h, l);
        if ($urandom_range(0, 19) == 0)
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(0, 1'($urandom));
      end
    end

    // Error counter saturation.
    exp_high = 8'd1; exp_low = 8'd1;
    for (int i = 0; i < 300; i++) drive_period(2, 2);
    check_eq("err_cnt_sat", err_cnt, MAXE);

    // Asynchronous reset mid-period clears outputs before the next edge.
    step(1, 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk) rst = 1'b0;
    step(1, 0);
    for (int i = 0; i < 6; i++) drive_period(1, 1);
    check_eq("post_rst_lock", locked, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Receive-side checker for divided clocks generated by the team's clock-divider FSMs. It samples a divided clock, already synchronous to the fast clock, once per fast-clock edge. It measures the high and low phase of every full period and compares them against programmed expected values. After a run of consecutive good periods it asserts lock; it flags every mismatch or stall.

Parameters:
CNT_W, 8, width of the phase counters, expected-value inputs and measured outputs
LOCK_CNT, 4, number of consecutive matching periods required to assert locked (1..15)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  fast reference clock; all logic is on its rising edge
rst  input  1  reset, asynchronous and active-high
enable  input  1  1 = monitor running; 0 = return to IDLE
div_in  input  1  divided clock under test, synchronous to clk
exp_high  input  CNT_W  expected high-phase length in clk cycles (quasi-static)
exp_low  input  CNT_W  expected low-phase length in clk cycles (quasi-static)
high_len  output  CNT_W  last measured high-phase length
low_len  output  CNT_W  last measured low-phase length
period_valid  output  1  one-cycle pulse when high_len/low_len are updated
locked  output  1  LOCK_CNT consecutive matching periods observed
err  output  1  one-cycle pulse on mismatch or timeout
err_cnt  output  ERR_W  saturating count of err pulses

Behaviour:
- Reset (rst=1, async): state=IDLE, div_d=0, hcnt=lcnt=0, good_cnt=0. All outputs are 0.
- div_d is a registered copy of div_in, updated every cycle in every state. rise = div_in & ~div_d.
- All outputs are registered and update on the clk edge that samples the triggering condition.
- FSM states: IDLE, SYNC, HIGH, LOW. enable=0 in any state forces IDLE next edge, with hcnt/lcnt/good_cnt cleared and locked=0. high_len, low_len and err_cnt hold their values.
- IDLE: on enable=1, go to SYNC.
- SYNC: wait for rise; the partial period before the first rise is discarded. On rise: HIGH, hcnt=1.
- HIGH: if div_in=1, hcnt++. If div_in=0: LOW, lcnt=1.
- LOW: if div_in=0, lcnt++. If div_in=1, the period is complete:
  - high_len<=hcnt, low_len<=lcnt, period_valid=1.
  - Next state is HIGH with hcnt=1.
- Period check, on the same edge as period completion:
  - Match (hcnt==exp_high and lcnt==exp_low): good_cnt++ saturating at LOCK_CNT. locked=1 once good_cnt reaches LOCK_CNT, i.e. on the edge of the LOCK_CNT-th consecutive match.
  - Mismatch: err=1, good_cnt=0, locked=0.
- Timeout: the active counter is all-ones and the level persists for one more sample (HIGH with div_in=1 while hcnt=max, or LOW with div_in=0 while lcnt=max). Then err=1, good_cnt=0, locked=0, next state SYNC, counters cleared, no period_valid.
- err_cnt increments on every err pulse and saturates at all-ones; only rst clears it.
- period_valid and err are single-cycle pulses; both may assert on the same edge (mismatch).
- Minimum measurable phase is 1 clk cycle, so divide-by-2 reads 1/1. A phase of 0 cannot occur.
- Changing exp_high/exp_low mid-run affects only periods completing afterwards.
- rst mid-period aborts immediately; monitoring restarts from IDLE once released.

Test Plan:
1. rst pulse, enable=1, exp_high=1, exp_low=1, LOCK_CNT=4, div_in toggles every clk starting 0. Required: period_valid every 2 cycles with high_len=1, low_len=1; locked=1 on the 4th period_valid; err never asserts.
2. exp_high=2, exp_low=1, div_in pattern 1,1,0 repeating (divide-by-3). Required: high_len=2, low_len=1 each period; locked after 4 periods.
3. Locked at 1/1, then div_in switched to 1,1,0,0 pattern. Required: first period reports 2/2 with err=1 and period_valid=1 on the same cycle; locked falls that edge; err_cnt increments per period.
4. CNT_W=8, locked in HIGH, div_in held at 1. Required: err pulse when the 256th high sample is taken at hcnt=255; state returns to SYNC; locked=0; no period_valid.
5. Mid-period, assert enable=0 for 3 cycles, then resume. Required: locked=0 immediately; high_len/low_len hold; the first partial period after SYNC is discarded; relock after 4 good periods.
6. Force 300 mismatched periods with ERR_W=8. Required: err_cnt saturates at 255. rst asserted asynchronously mid-period clears all outputs before the next clk edge.
